// File: rtl/mips_pkg.sv
// Shared MIPS core types: MDU opcodes, MDU FSM states and datapath width.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_RUN,
    MDU_FINISH
  } mdu_state_t;

endpackage

// File: rtl/mdu_divider_core.sv
// One restoring-division step on unsigned magnitudes; only built when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_divider_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor holds between steps, so diff[WIDTH] is a clean borrow flag
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`endif

// File: rtl/multiply_divide_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO and stall request; divider present only
// when MDU_DIV_EN is defined, otherwise DIV/DIVU are silently dropped.
module multiply_divide_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_execute,
  input  logic [2:0]       mdu_op_execute,
  input  logic [WIDTH-1:0] src_a_execute,
  input  logic [WIDTH-1:0] src_b_execute,
  input  logic             cancel_execute,
  input  logic             hilo_read_decode,
  input  logic             mdu_op_decode,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_request_mdu
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  mdu_state_t       state;
  logic [CNT_W-1:0] counter;
  mdu_op_t          op_sel;
  logic             op_is_mul, op_is_div, op_signed;
  logic             sign_a_in, sign_b_in, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo;
  logic             neg_res, sign_a, op_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_sel    = mdu_op_t'(mdu_op_execute);
  assign op_is_mul = (op_sel == MDU_MULT) || (op_sel == MDU_MULTU);
  assign op_signed = (op_sel == MDU_MULT) || (op_sel == MDU_DIV);
  assign sign_a_in = op_signed & src_a_execute[WIDTH-1];
  assign sign_b_in = op_signed & src_b_execute[WIDTH-1];
  assign abs_a     = negate_w(src_a_execute, sign_a_in);
  assign abs_b     = negate_w(src_b_execute, sign_b_in);
  assign accept    = start_execute && !cancel_execute && (state == MDU_IDLE)
                     && (op_is_mul || op_is_div);

`ifdef MDU_DIV_EN
  assign op_is_div = (op_sel == MDU_DIV) || (op_sel == MDU_DIVU);

  mdu_divider_core #(.WIDTH(WIDTH)) u_divider (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (mag_b),
    .rem_next (div_hi_next),
    .quo_next (div_lo_next)
  );
`else
  assign op_is_div   = 1'b0;
  assign div_hi_next = acc_hi;
  assign div_lo_next = acc_lo;
`endif

  // Shift-add: acc_lo starts as the multiplier and drains out as product bits shift in
  assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // ---- finish stage: sign correction and divide-by-zero override ----
  assign prod_res = negate_2w({acc_hi, acc_lo}, neg_res);

  always_comb begin
    res_hi = prod_res[2*WIDTH-1:WIDTH];
    res_lo = prod_res[WIDTH-1:0];
    if (op_div) begin
      if (mag_b == '0) begin
        res_lo = '1;
        res_hi = negate_w(mag_a, sign_a);
      end else begin
        res_lo = negate_w(acc_lo, neg_res);
        res_hi = negate_w(acc_hi, sign_a);
      end
    end
  end

  // ---- operand capture and iteration datapath (no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_a   <= abs_a;
      mag_b   <= abs_b;
      acc_hi  <= '0;
      acc_lo  <= op_is_div ? abs_a : abs_b;
      neg_res <= sign_a_in ^ sign_b_in;
      sign_a  <= sign_a_in;
      op_div  <= op_is_div;
    end else if (state == MDU_RUN) begin
      if (op_div) begin
        acc_hi <= div_hi_next;
        acc_lo <= div_lo_next;
      end else begin
        acc_hi <= mul_hi_next;
        acc_lo <= mul_lo_next;
      end
    end
  end

  // ---- control FSM and architectural HI/LO ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MDU_IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            state   <= MDU_RUN;
            busy    <= 1'b1;
            counter <= CNT_W'(WIDTH - 1);
          end else if (start_execute && !cancel_execute) begin
            if (op_sel == MDU_MTHI) hi <= src_a_execute;
            else if (op_sel == MDU_MTLO) lo <= src_a_execute;
          end
        end
        MDU_RUN: begin
          if (cancel_execute) begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
          end else if (counter == '0) begin
            state <= MDU_FINISH;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        MDU_FINISH: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
          if (!cancel_execute) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_request_mdu = busy && (hilo_read_decode || mdu_op_decode);

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed table-driven bench for multiply_divide_unit; expectations follow MDU_DIV_EN.
module tb_multiply_divide_unit;
  import mips_pkg::*;

  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic         hilo_rd = 1'b0;
  logic         op_dec = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int total = 0;
  int bad = 0;
  vec_t vecs [16];

  always #5 clk = ~clk;

  multiply_divide_unit #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_execute     (start),
    .mdu_op_execute    (op),
    .src_a_execute     (a),
    .src_b_execute     (b),
    .cancel_execute    (cancel),
    .hilo_read_decode  (hilo_rd),
    .mdu_op_decode     (op_dec),
    .hi                (hi),
    .lo                (lo),
    .busy              (busy),
    .done              (done),
    .stall_request_mdu (stall)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_busy, input string tag);
    int nbusy = 0;
    int ndone = 0;
    int done_at = -1;
    int nstall_bad = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        done_at = i;
      end
      if (stall !== ((i < exp_busy) && (hilo_rd || op_dec))) nstall_bad++;
    end
    check({tag, " busy cycles"}, nbusy, exp_busy);
    check({tag, " done pulses"}, ndone, (exp_busy > 0) ? 1 : 0);
    check({tag, " done cycle"}, done_at, (exp_busy > 0) ? exp_busy : -1);
    check({tag, " stall errors"}, nstall_bad, 0);
  endtask

  initial begin
    logic [W-1:0] m_hi, m_lo, e_hi, e_lo;
    logic         is_div, is_mul;
    int           exp_busy, nbusy, ndone;
    logic         busy_at10, busy_at11;

    vecs[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{MDU_MULT,  32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE};
    vecs[4]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5]  = '{MDU_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{MDU_MTHI,  32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[7]  = '{MDU_MTLO,  32'h0BAD_BEEF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    vecs[8]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[9]  = '{MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[10] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[11] = '{MDU_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[12] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[13] = '{MDU_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[14] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[15] = '{MDU_MULT,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};

    // reset state
    repeat (3) @(negedge clk);
    hilo_rd = 1'b1;
    #1;
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", busy, '0);
    check("reset done", done, '0);
    check("reset stall", stall, '0);
    hilo_rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < 16; i++) begin
      is_mul = (vecs[i].op == MDU_MULT) || (vecs[i].op == MDU_MULTU);
      is_div = (vecs[i].op == MDU_DIV) || (vecs[i].op == MDU_DIVU);
      exp_busy = (is_mul || (is_div && DIV_EN)) ? 33 : 0;
      e_hi = (is_div && !DIV_EN) ? m_hi : vecs[i].hi;
      e_lo = (is_div && !DIV_EN) ? m_lo : vecs[i].lo;
      hilo_rd = (i % 3 == 1);
      op_dec  = (i % 3 == 2);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, exp_busy, $sformatf("vec%0d", i));
      check($sformatf("vec%0d hi", i), hi, e_hi);
      check($sformatf("vec%0d lo", i), lo, e_lo);
      m_hi = e_hi;
      m_lo = e_lo;
    end
    hilo_rd = 1'b0;
    op_dec  = 1'b0;

    // cancel in RUN after MTHI/MTLO
    run_op(MDU_MTHI, 32'h0000_5678, '0, 0, "mthi");
    run_op(MDU_MTLO, 32'h0000_1234, '0, 0, "mtlo");
    @(negedge clk);
    op = MDU_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
    ndone = 0;
    busy_at10 = 1'b0;
    busy_at11 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      if (i == 10) busy_at10 = busy;
      if (i == 11) busy_at11 = busy;
      cancel = (i == 10);
    end
    check("cancel busy before", busy_at10, 1'b1);
    check("cancel busy after", busy_at11, 1'b0);
    check("cancel done pulses", ndone, 0);
    check("cancel hi", hi, 32'h0000_5678);
    check("cancel lo", lo, 32'h0000_1234);

    // cancel together with start in IDLE
    @(negedge clk);
    op = MDU_MTLO; a = 32'h0000_9999; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    op = MDU_MULT; a = 32'd3; b = 32'd3;
    check("cancel+mtlo lo", lo, 32'h0000_1234);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel+mult busy", busy, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    op = MDU_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin
        op = MDU_MTHI;
        a = 32'hDEAD_0000;
      end
      if (busy) nbusy++;
    end
    check("busy-start busy cycles", nbusy, 33);
    check("busy-start hi", hi, 32'h0000_0000);
    check("busy-start lo", lo, 32'h0000_0006);

    // asynchronous reset mid-operation
    run_op(MDU_MTHI, 32'h0000_1111, '0, 0, "mthi2");
    @(negedge clk);
    op = DIV_EN ? MDU_DIV : MDU_MULTU;
    a = 32'hFFFF_FFF9; b = 32'h0000_0002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midop reset busy", busy, 1'b0);
    check("midop reset hi", hi, '0);
    check("midop reset lo", lo, '0);
    @(negedge clk);
    reset_n = 1'b1;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
    end
    check("post-reset busy", nbusy, 0);
    check("post-reset done", ndone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
